maxnet_iterator: RTL and testbench



---
 rtl/maxnet_iterator.sv | 153 +++++++++++++++
 tb/tb_maxnet_iterator.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_iterator.sv
// maxnet_iterator: sequential four-neuron Maxnet winner-take-all engine.
// Define MAXNET_ITER_COUNT_EN to build the iteration counter, MAX_ITER cap and timeout path.
module maxnet_iterator #(
    parameter int WIDTH     = 8,
    parameter int EPS_SHIFT = 3,
    parameter int MAX_ITER  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic             busy,
    output logic             done,
    output logic [3:0]       winner_onehot,
    output logic [1:0]       winner_idx,
    output logic             none_flag,
    output logic             timeout,
    output logic [7:0]       iter_count
);
    // state | meaning
    // IDLE  | waiting for start; previous result held
    // RUN   | one lateral-inhibition update per cycle until converged (or capped)
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SW = WIDTH + 2;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] r     [4];
    logic [WIDTH-1:0] r_upd [4];
    logic [SW-1:0]    o     [4];
    logic [SW-1:0]    d     [4];
    logic [SW-1:0]    sum;
    logic [3:0]       nz;
    logic             converged, cap_hit;
    logic             load, step, latch_res, latch_tmo;

    assign nz        = {r[3] != '0, r[2] != '0, r[1] != '0, r[0] != '0};
    assign converged = (nz & (nz - 4'd1)) == 4'd0;

    // All lanes update from the old values; the floor of 1 guarantees progress.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) sum = sum + SW'(r[i]);
        for (int i = 0; i < 4; i++) begin
            o[i] = sum - SW'(r[i]);
            d[i] = o[i] >> EPS_SHIFT;
            if (d[i] == '0 && o[i] != '0) d[i] = SW'(1);
            r_upd[i] = (SW'(r[i]) > d[i]) ? WIDTH'(SW'(r[i]) - d[i]) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        latch_res = 1'b0;
        latch_tmo = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (converged) begin
                    latch_res = 1'b1;
                    state_nxt = DONE;
                end else if (cap_hit) begin
                    latch_tmo = 1'b1;
                    state_nxt = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r[i] <= '0;
            winner_onehot <= '0;
            winner_idx    <= '0;
            none_flag     <= 1'b0;
        end else begin
            if (load) begin
                r[0]          <= x0;
                r[1]          <= x1;
                r[2]          <= x2;
                r[3]          <= x3;
                winner_onehot <= '0;
                winner_idx    <= '0;
                none_flag     <= 1'b0;
            end else if (step) begin
                for (int i = 0; i < 4; i++) r[i] <= r_upd[i];
            end
            if (latch_res) begin
                winner_onehot <= nz;
                winner_idx    <= {nz[3] | nz[2], nz[3] | nz[1]};
                none_flag     <= (nz == 4'd0);
            end else if (latch_tmo) begin
                winner_onehot <= '0;
                winner_idx    <= '0;
                none_flag     <= 1'b0;
            end
        end
    end

`ifdef MAXNET_ITER_COUNT_EN
    logic [7:0] iter_q;
    logic       timeout_q;

    assign cap_hit = (int'(iter_q) == MAX_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_q    <= '0;
            timeout_q <= 1'b0;
        end else if (load) begin
            iter_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (step && iter_q != 8'hFF) iter_q <= iter_q + 8'd1;
            if (latch_tmo) timeout_q <= 1'b1;
        end
    end

    assign iter_count = iter_q;
    assign timeout    = timeout_q;
`else
    localparam int unused_max_iter = MAX_ITER;
    assign cap_hit    = 1'b0;
    assign iter_count = '0;
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_iterator.sv
// Self-checking bench for maxnet_iterator: scoreboard of expected results, one task per scenario.
`timescale 1ns/1ps
module tb_maxnet_iterator;
    localparam int EPS_SHIFT = 3;
`ifdef MAXNET_ITER_COUNT_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] oh;
        logic [1:0] idx;
        logic       none;
        logic       tmo;
        logic [7:0] iter;
    } res_t;

    typedef struct {
        res_t res;
        int   cyc;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] a, b, c, d;
        bit         cap;
        res_t       res;
        int         cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;

    logic       busy_a, done_a, none_a, tmo_a, busy_b, done_b, none_b, tmo_b;
    logic [3:0] oh_a, oh_b;
    logic [1:0] idx_a, idx_b;
    logic [7:0] iter_a, iter_b;
    res_t       res_a, res_b;

    assign res_a = {oh_a, idx_a, none_a, tmo_a, iter_a};
    assign res_b = {oh_b, idx_b, none_b, tmo_b, iter_b};

    maxnet_iterator #(.WIDTH(8), .EPS_SHIFT(EPS_SHIFT), .MAX_ITER(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .busy(busy_a), .done(done_a), .winner_onehot(oh_a), .winner_idx(idx_a),
        .none_flag(none_a), .timeout(tmo_a), .iter_count(iter_a)
    );

    maxnet_iterator #(.WIDTH(8), .EPS_SHIFT(EPS_SHIFT), .MAX_ITER(1)) dut_cap (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .busy(busy_b), .done(done_b), .winner_onehot(oh_b), .winner_idx(idx_b),
        .none_flag(none_b), .timeout(tmo_b), .iter_count(iter_b)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    res_t obs;
    int   obs_cyc, obs_busy;
    bit   obs_got;

    function automatic logic [7:0] it(input int n);
        return CAP_EN ? 8'(n) : 8'd0;
    endfunction

    // Reference Maxnet: applies the update rule directly until the exit condition.
    function automatic exp_t model(input logic [7:0] a, b, c, d, input int max_iter);
        int   r[4], nr[4];
        int   s, o, dd, n, nz;
        exp_t e;
        r = '{int'(a), int'(b), int'(c), int'(d)};
        n = 0;
        e.res = '0;
        for (int k = 0; k < 5000; k++) begin
            nz = 0;
            for (int i = 0; i < 4; i++) if (r[i] != 0) nz++;
            if (nz <= 1) begin
                for (int i = 0; i < 4; i++) begin
                    e.res.oh[i] = (r[i] != 0);
                    if (r[i] != 0) e.res.idx = 2'(i);
                end
                e.res.none = (nz == 0);
                break;
            end
            if (CAP_EN && n == max_iter) begin
                e.res.tmo = 1'b1;
                break;
            end
            s = r[0] + r[1] + r[2] + r[3];
            for (int i = 0; i < 4; i++) begin
                o  = s - r[i];
                dd = o >> EPS_SHIFT;
                if (dd == 0 && o != 0) dd = 1;
                nr[i] = (r[i] > dd) ? r[i] - dd : 0;
            end
            r = nr;
            n++;
        end
        e.res.iter = CAP_EN ? 8'((n > 255) ? 255 : n) : 8'd0;
        e.cyc = n + 2;
        return e;
    endfunction

    // Drives one start in the next IDLE cycle, then waits (bounded) for done.
    // poke_k >= 0 re-asserts start with different inputs in that RUN cycle.
    task automatic run(input logic [7:0] a, b, c, d, input bit use_cap, input int poke_k);
        int k;
        @(negedge clk);
        x0 = a; x1 = b; x2 = c; x3 = d;
        start = 1'b1;
        @(posedge clk);
        k = 0;
        obs_got = 1'b0;
        obs_busy = 0;
        obs_cyc = -1;
        obs = '0;
        while (k < 4000 && !obs_got) begin
            @(negedge clk);
            if (k == poke_k) begin
                x0 = 8'd0; x1 = 8'd0; x2 = 8'd50; x3 = 8'd0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (use_cap ? busy_b : busy_a) obs_busy++;
            if (use_cap ? done_b : done_a) begin
                obs_got = 1'b1;
                obs_cyc = k + 1;
                obs = use_cap ? res_b : res_a;
            end else begin
                @(posedge clk);
                k++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy_a, done_a, res_a, busy_b, done_b, res_b} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=0", {busy_a, done_a, res_a, busy_b, done_b, res_b});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        vec_t v[6];
        exp_t e;
        v[0] = '{"single",   8'd0,   8'd0,  8'd50, 8'd0,   1'b0, '{4'b0100, 2'd2, 1'b0, 1'b0, it(0)}, 2};
        v[1] = '{"allzero",  8'd0,   8'd0,  8'd0,  8'd0,   1'b0, '{4'b0000, 2'd0, 1'b1, 1'b0, it(0)}, 2};
        v[2] = '{"decay",    8'd100, 8'd20, 8'd20, 8'd20,  1'b0, '{4'b0001, 2'd0, 1'b0, 1'b0, it(2)}, 4};
        v[3] = '{"tie",      8'd40,  8'd40, 8'd0,  8'd0,   1'b0, '{4'b0000, 2'd0, 1'b1, 1'b0, it(23)}, 25};
        v[4] = '{"lane3max", 8'd0,   8'd0,  8'd0,  8'd255, 1'b0, '{4'b1000, 2'd3, 1'b0, 1'b0, it(0)}, 2};
        if (CAP_EN) v[5] = '{"cap", 8'd100, 8'd20, 8'd20, 8'd20, 1'b1, '{4'b0000, 2'd0, 1'b0, 1'b1, 8'd1}, 3};
        else        v[5] = '{"cap", 8'd100, 8'd20, 8'd20, 8'd20, 1'b1, '{4'b0001, 2'd0, 1'b0, 1'b0, 8'd0}, 4};
        foreach (v[i]) begin
            sb.push_back('{v[i].res, v[i].cyc});
            run(v[i].a, v[i].b, v[i].c, v[i].d, v[i].cap, -1);
            e = sb.pop_front();
            n_vec++;
            if (obs_cyc != e.cyc) begin
                n_err++;
                $display("FAIL %s done_cycle got=%0d exp=%0d", v[i].name, obs_cyc, e.cyc);
            end
            n_vec++;
            if (obs !== e.res) begin
                n_err++;
                $display("FAIL %s result got=%h exp=%h", v[i].name, obs, e.res);
            end
            n_vec++;
            if (obs_busy != e.cyc - 1) begin
                n_err++;
                $display("FAIL %s busy_cycles got=%0d exp=%0d", v[i].name, obs_busy, e.cyc - 1);
            end
        end
    endtask

    task automatic test_hold();
        res_t want;
        bit   bad;
        want = '{4'b1000, 2'd3, 1'b0, 1'b0, it(0)};
        run(8'd0, 8'd0, 8'd0, 8'd255, 1'b0, -1);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0 || res_a !== want) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL hold got=%h done=%b exp=%h done=0", res_a, done_a, want);
        end
    endtask

    task automatic test_restart_ignored();
        exp_t e;
        sb.push_back('{'{4'b0001, 2'd0, 1'b0, 1'b0, it(2)}, 4});
        run(8'd100, 8'd20, 8'd20, 8'd20, 1'b0, 1);
        e = sb.pop_front();
        n_vec++;
        if (obs_cyc != e.cyc || obs !== e.res) begin
            n_err++;
            $display("FAIL restart_ignored got=%h@%0d exp=%h@%0d", obs, obs_cyc, e.res, e.cyc);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back('{'{4'b0001, 2'd0, 1'b0, 1'b0, it(2)}, 4});
        sb.push_back('{'{4'b0100, 2'd2, 1'b0, 1'b0, it(0)}, 2});
        run(8'd100, 8'd20, 8'd20, 8'd20, 1'b0, -1);
        e = sb.pop_front();
        n_vec++;
        if (obs_cyc != e.cyc || obs !== e.res) begin
            n_err++;
            $display("FAIL b2b_first got=%h@%0d exp=%h@%0d", obs, obs_cyc, e.res, e.cyc);
        end
        run(8'd0, 8'd0, 8'd50, 8'd0, 1'b0, -1);
        e = sb.pop_front();
        n_vec++;
        if (obs_cyc != e.cyc || obs !== e.res) begin
            n_err++;
            $display("FAIL b2b_second got=%h@%0d exp=%h@%0d", obs, obs_cyc, e.res, e.cyc);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        bit   saw_done;
        @(negedge clk);
        x0 = 8'd100; x1 = 8'd20; x2 = 8'd20; x3 = 8'd20;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy_a, done_a, res_a, busy_b, done_b, res_b} !== '0) begin
            n_err++;
            $display("FAIL reset_abort got=%h exp=0", {busy_a, done_a, res_a, busy_b, done_b, res_b});
        end
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_a || done_b || busy_a) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done_a || done_b || busy_a) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL reset_no_done got=activity exp=quiet");
        end
        sb.push_back('{'{4'b0100, 2'd2, 1'b0, 1'b0, it(0)}, 2});
        run(8'd0, 8'd0, 8'd50, 8'd0, 1'b0, -1);
        e = sb.pop_front();
        n_vec++;
        if (obs_cyc != e.cyc || obs !== e.res) begin
            n_err++;
            $display("FAIL after_reset got=%h@%0d exp=%h@%0d", obs, obs_cyc, e.res, e.cyc);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, c, d;
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = (n % 3 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            sb.push_back(model(a, b, c, d, 64));
            run(a, b, c, d, 1'b0, -1);
            e = sb.pop_front();
            n_vec++;
            if (obs_cyc != e.cyc || obs !== e.res) begin
                n_err++;
                $display("FAIL random x=(%0d,%0d,%0d,%0d) got=%h@%0d exp=%h@%0d",
                         a, b, c, d, obs, obs_cyc, e.res, e.cyc);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired, simulation hung");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_restart_ignored();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
